cga_vram_arbiter: RTL
=====================

CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 Parameter: RD_LATENCY, default 1, RAM read latency in clk cycles (legal values: 1 or 2).
REQ-002 clk  in  1  system clock; all logic samples on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 isa_op_enable  in  1  sequencer marks a CPU-usable RAM slot (display not fetching).
REQ-005 disp_addr  in  19  display fetch address from the CRTC/sequencer path.
REQ-006 mem_cs  in  1  framebuffer window decode (B8000-BFFFF).
REQ-007 bus_a  in  15  ISA address within the window.
REQ-008 bus_memr_l, bus_memw_l  in  1 each  raw ISA memory strobes, active low, asynchronous.
REQ-009 bus_d  in  8  ISA write data.
REQ-010 ram_d  in  8  RAM read data.
REQ-011 bus_out  out  8  CPU read data.
REQ-012 bus_dir  out  1  high while bus_out is driven.
REQ-013 bus_rdy  out  1  ISA ready; low inserts wait states.
REQ-014 ram_a  out  19  RAM address.
REQ-015 ram_dout  out  8  RAM write data.
REQ-016 ram_we_l  out  1  RAM write enable, active low.
REQ-017 cpu_grant  out  1  high in the cycle the CPU owns the RAM port.

Function
REQ-018 The block SHALL synchronize bus_memr_l and bus_memw_l through two flops; decisions SHALL use only the synchronized values.
REQ-019 The request SHALL be req = mem_cs & (~memr_s | ~memw_s); when both strobes are low, write SHALL take precedence.
REQ-020 The FSM SHALL have states IDLE, WAIT_SLOT, ACCESS, RDWAIT, DONE.
REQ-021 IDLE: on req, latch bus_a, bus_d and the rd/wr type, drop bus_rdy, and go to WAIT_SLOT.
REQ-022 WAIT_SLOT: on the first cycle with isa_op_enable=1, go to ACCESS; otherwise hold with bus_rdy=0.
REQ-023 ACCESS (exactly 1 cycle): cpu_grant=1; ram_a={4'h0, latched addr}.
REQ-024 For a write in ACCESS: ram_dout=latched data, ram_we_l=0 for this cycle only, then go to DONE.
REQ-025 For a read in ACCESS: go to RDWAIT.
REQ-026 RDWAIT SHALL last RD_LATENCY cycles, then capture ram_d into a bus_out register and go to DONE.
REQ-027 DONE: bus_rdy=1; bus_dir=1 for reads.
REQ-028 DONE: once req deasserts, return to IDLE; bus_dir SHALL fall in the same cycle req deasserts.
REQ-029 Outside ACCESS, ram_a SHALL equal disp_addr and ram_we_l SHALL be 1.
REQ-030 A new access SHALL never start before the previous strobe is seen released; back-to-back cycles SHALL return through IDLE.
REQ-031 A request arriving with isa_op_enable already high SHALL reach ACCESS exactly two cycles later (IDLE, then WAIT_SLOT).
REQ-032 mem_cs low with strobes active SHALL leave the FSM in IDLE, keep bus_rdy=1 and keep bus_dir=0.
REQ-033 A wait counter (6 bits, saturating at 63) SHALL count WAIT_SLOT cycles and clear in IDLE; it is debug-visible only and does not alter behaviour.

Reset
REQ-034 On reset the FSM SHALL enter IDLE with bus_rdy=1, bus_dir=0, cpu_grant=0, ram_we_l=1, bus_out=8'h00, and the sync flops set to 1.
REQ-035 Reset asserted mid-access SHALL abort the access with no RAM write after the reset edge; any later transaction SHALL need a fresh strobe.

Configuration
REQ-036 Macro CGA_SNOW_EN, when defined: WAIT_SLOT SHALL be skipped, so IDLE goes directly to ACCESS regardless of isa_op_enable.
REQ-037 With CGA_SNOW_EN defined, the display path sees CPU data in the stolen cycle (CGA snow); bus_rdy still drops for the IDLE-to-DONE sequence.
REQ-038 Macro CGA_SNOW_EN, when undefined: CPU access SHALL occur only in isa_op_enable slots, and display fetches SHALL never be disturbed.

Verification
REQ-039 Write, slot available: bus_a=15'h0123, bus_d=8'hA5, memw low, isa_op_enable=1 -> one ram_we_l low pulse with ram_a=19'h00123 and ram_dout=8'hA5; bus_rdy high 4 cycles after the sync'd strobe.
REQ-040 Read, delayed slot: ram_d=8'h3C at addr 15'h7FFF, isa_op_enable low for 20 cycles -> bus_rdy low throughout; then bus_out=8'h3C, bus_dir=1 until memr high.
REQ-041 Contention: isa_op_enable=0 during a write request -> ram_a tracks disp_addr and ram_we_l=1 every cycle until a slot arrives.
REQ-042 Reset in WAIT_SLOT: reset for 1 cycle -> no ram_we_l pulse, bus_rdy=1, FSM in IDLE; the held strobe re-arms only after release and re-assert.
REQ-043 Out-of-window: mem_cs=0 with memr low -> bus_dir=0, bus_rdy=1, cpu_grant never asserted.
REQ-044 With CGA_SNOW_EN defined: write with isa_op_enable=0 -> ACCESS in the cycle after IDLE; ram_we_l pulse occurs with isa_op_enable still 0.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// CGA framebuffer arbiter: shares one VRAM port between the display fetch
// path and ISA CPU accesses. The CPU is granted single cycles in display
// idle slots (isa_op_enable); reads wait RD_LATENCY cycles for RAM data.
// Optional build macro CGA_SNOW_EN: CPU steals the port immediately,
// ignoring isa_op_enable (reproduces original CGA snow).
module cga_vram_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isa_op_enable,
  input  logic [18:0] disp_addr,
  input  logic        mem_cs,
  input  logic [14:0] bus_a,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [7:0]  bus_d,
  input  logic [7:0]  ram_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we_l,
  output logic        cpu_grant,
  output logic [5:0]  dbg_wait_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SLOT = 3'd1;
  localparam logic [2:0] ACCESS    = 3'd2;
  localparam logic [2:0] RDWAIT    = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  // [0] = first sync stage, [1] = stage used by the logic
  logic [1:0]  memr_sync_q, memw_sync_q;
  // Fills with ones after reset; [1] set means the sync outputs reflect the
  // real pins rather than their reset value.
  logic [1:0]  fill_q;
  logic [2:0]  state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rd_q, rd_d;
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  bus_out_q, bus_out_d;
  // Set once both strobes are seen released; a transaction needs it, so a
  // strobe held across reset or completion cannot start a second access.
  logic        armed_q, armed_d;
  logic [5:0]  wait_cnt_q, wait_cnt_d;

  logic memr_s, memw_s, req, released;

  assign memr_s   = memr_sync_q[1];
  assign memw_s   = memw_sync_q[1];
  assign req      = mem_cs & (~memr_s | ~memw_s);
  assign released = memr_s & memw_s & fill_q[1];

  // Two-flop synchronizers for the asynchronous ISA strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      memr_sync_q <= 2'b11;
      memw_sync_q <= 2'b11;
      fill_q      <= 2'b00;
    end else begin
      memr_sync_q <= {memr_sync_q[0], bus_memr_l};
      memw_sync_q <= {memw_sync_q[0], bus_memw_l};
      fill_q      <= {fill_q[0], 1'b1};
    end
  end

  // Next-state logic for the access sequencer and its latched transaction
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    lat_d      = lat_q;
    bus_out_d  = bus_out_q;
    armed_d    = armed_q;
    wait_cnt_d = wait_cnt_q;
    if (released) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        wait_cnt_d = 6'd0;
        if (req && armed_q) begin
          addr_d  = bus_a;
          data_d  = bus_d;
          rd_d    = memw_s;            // write wins when both strobes are low
          armed_d = 1'b0;
`ifdef CGA_SNOW_EN
          state_d = ACCESS;
`else
          state_d = WAIT_SLOT;
`endif
        end
      end
      WAIT_SLOT: begin
        if (wait_cnt_q != 6'h3f) wait_cnt_d = wait_cnt_q + 6'd1;
        if (isa_op_enable) state_d = ACCESS;
      end
      ACCESS: begin
        lat_d   = 2'd0;
        state_d = rd_q ? RDWAIT : DONE;
      end
      RDWAIT: begin
        if (lat_q == LAT_LAST) begin
          bus_out_d = ram_d;
          state_d   = DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= 1'b0;
      lat_q      <= '0;
      bus_out_q  <= 8'h00;
      armed_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      lat_q      <= lat_d;
      bus_out_q  <= bus_out_d;
      armed_q    <= armed_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Port muxing: the display owns the RAM except in the single ACCESS cycle
  always_comb begin
    cpu_grant    = (state_q == ACCESS);
    ram_a        = cpu_grant ? {4'h0, addr_q} : disp_addr;
    ram_we_l     = ~(cpu_grant & ~rd_q);
    ram_dout     = data_q;
    bus_rdy      = (state_q == IDLE) | (state_q == DONE);
    bus_dir      = (state_q == DONE) & rd_q & req;
    bus_out      = bus_out_q;
    dbg_wait_cnt = wait_cnt_q;
  end

endmodule
